// File: rtl/banked_reg_bank.sv
// General-purpose register bank with registered read ports, a user/kernel
// mode bit and a hidden kernel stack pointer swapped in on trap/return.
module banked_reg_bank #(
  parameter int REGISTER_LENGTH   = 32,
  parameter int ADDR_WIDTH        = 32,
  parameter int REG_ADDR_WIDTH    = 4,
  parameter int PC_REGISTER       = 15,
  parameter int SP_REGISTER       = 14,
  parameter int LR_REGISTER       = 13,
  parameter int SAVED_SP_REGISTER = 5,
  parameter int SYSCALL_REGISTER  = 7,
  parameter int SPECREG_LENGTH    = 4,
  parameter int USER_STACK        = 8191,
  parameter int KERNEL_STACK      = 6143,
  parameter int OS_START          = 2048
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [2:0]                 control,
  input  logic [REG_ADDR_WIDTH-1:0]  register_source_A,
  input  logic [REG_ADDR_WIDTH-1:0]  register_source_B,
  input  logic [REG_ADDR_WIDTH-1:0]  register_Dest,
  input  logic [REGISTER_LENGTH-1:0] ALU_result,
  input  logic [REGISTER_LENGTH-1:0] data_from_memory,
  input  logic [REGISTER_LENGTH-1:0] new_SP,
  input  logic [ADDR_WIDTH-1:0]      new_PC,
  input  logic [SPECREG_LENGTH-1:0]  special_register,
  output logic [REGISTER_LENGTH-1:0] read_data_A,
  output logic [REGISTER_LENGTH-1:0] read_data_B,
  output logic [REGISTER_LENGTH-1:0] memory_output,
  output logic [REGISTER_LENGTH-1:0] current_PC,
  output logic [REGISTER_LENGTH-1:0] current_SP,
  output logic                       kernel_mode,
  output logic                       trap_fault
);

  localparam int NUM_REGS = 2**REG_ADDR_WIDTH;

  localparam logic [REG_ADDR_WIDTH-1:0] PC_IDX  = REG_ADDR_WIDTH'(PC_REGISTER);
  localparam logic [REG_ADDR_WIDTH-1:0] SP_IDX  = REG_ADDR_WIDTH'(SP_REGISTER);
  localparam logic [REG_ADDR_WIDTH-1:0] LR_IDX  = REG_ADDR_WIDTH'(LR_REGISTER);
  localparam logic [REG_ADDR_WIDTH-1:0] SSP_IDX = REG_ADDR_WIDTH'(SAVED_SP_REGISTER);
  localparam logic [REG_ADDR_WIDTH-1:0] SYS_IDX = REG_ADDR_WIDTH'(SYSCALL_REGISTER);

  localparam logic [REGISTER_LENGTH-1:0] USER_SP_INIT   = REGISTER_LENGTH'(USER_STACK);
  localparam logic [REGISTER_LENGTH-1:0] KERNEL_SP_INIT = REGISTER_LENGTH'(KERNEL_STACK);
  localparam logic [REGISTER_LENGTH-1:0] OS_ENTRY       = REGISTER_LENGTH'(OS_START);

  localparam logic [2:0] OP_ALU  = 3'd1;
  localparam logic [2:0] OP_MEM  = 3'd3;
  localparam logic [2:0] OP_TRAP = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;
  localparam logic [2:0] OP_SPEC = 3'd6;

  function automatic logic [REGISTER_LENGTH-1:0] zext_pc(input logic [ADDR_WIDTH-1:0] v);
    zext_pc = '0;
    zext_pc[ADDR_WIDTH-1:0] = v;
  endfunction

  function automatic logic [REGISTER_LENGTH-1:0] zext_spec(input logic [SPECREG_LENGTH-1:0] v);
    zext_spec = '0;
    zext_spec[SPECREG_LENGTH-1:0] = v;
  endfunction

  logic [REGISTER_LENGTH-1:0] regs     [NUM_REGS];
  logic [REGISTER_LENGTH-1:0] regs_nxt [NUM_REGS];
  logic [REGISTER_LENGTH-1:0] shadow_sp;
  logic [REGISTER_LENGTH-1:0] shadow_sp_nxt;
  logic                       kernel_mode_nxt;
  logic                       trap_fault_nxt;
  logic                       dest_protected;
  logic [REGISTER_LENGTH-1:0] pc_ext;

  assign dest_protected = (register_Dest == PC_IDX) || (register_Dest == SP_IDX);
  assign pc_ext         = zext_pc(new_PC);

  // Stage p0: next-state computed from pre-edge values only (parallel assignment)
  always_comb begin
    regs_nxt        = regs;
    shadow_sp_nxt   = shadow_sp;
    kernel_mode_nxt = kernel_mode;
    trap_fault_nxt  = 1'b0;
    if (enable) begin
      case (control)
        OP_ALU: begin
          if (!dest_protected) regs_nxt[register_Dest] = ALU_result;
          regs_nxt[PC_IDX] = pc_ext;
        end
        OP_MEM: begin
          if (!dest_protected) regs_nxt[register_Dest] = data_from_memory;
          regs_nxt[SP_IDX] = new_SP;
          regs_nxt[PC_IDX] = pc_ext;
        end
        OP_TRAP: begin
          if (!kernel_mode) begin
            regs_nxt[SSP_IDX] = regs[SP_IDX];
            regs_nxt[LR_IDX]  = regs[PC_IDX];
            regs_nxt[SP_IDX]  = shadow_sp;
            regs_nxt[PC_IDX]  = OS_ENTRY;
            regs_nxt[SYS_IDX] = ALU_result;
            kernel_mode_nxt   = 1'b1;
          end else begin
            regs_nxt[PC_IDX] = pc_ext;
            trap_fault_nxt   = 1'b1;
          end
        end
        OP_RET: begin
          if (kernel_mode) begin
            shadow_sp_nxt    = regs[SP_IDX];
            regs_nxt[SP_IDX] = regs[SSP_IDX];
            regs_nxt[PC_IDX] = regs[LR_IDX];
            kernel_mode_nxt  = 1'b0;
          end else begin
            regs_nxt[PC_IDX] = pc_ext;
            trap_fault_nxt   = 1'b1;
          end
        end
        OP_SPEC: begin
          if (!dest_protected) regs_nxt[register_Dest] = zext_spec(special_register);
          regs_nxt[PC_IDX] = pc_ext;
        end
        default: begin
          regs_nxt[SP_IDX] = new_SP;
          regs_nxt[PC_IDX] = pc_ext;
        end
      endcase
    end
  end

  // Stage p1: architectural state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      regs[SP_IDX] <= USER_SP_INIT;
      shadow_sp    <= KERNEL_SP_INIT;
      kernel_mode  <= 1'b0;
      trap_fault   <= 1'b0;
    end else begin
      regs        <= regs_nxt;
      shadow_sp   <= shadow_sp_nxt;
      kernel_mode <= kernel_mode_nxt;
      trap_fault  <= trap_fault_nxt;
    end
  end

  // Stage p1: read ports sample post-edge values, giving same-cycle write forwarding
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_data_A   <= '0;
      read_data_B   <= '0;
      memory_output <= '0;
    end else begin
      read_data_A   <= regs_nxt[register_source_A];
      read_data_B   <= regs_nxt[register_source_B];
      memory_output <= regs_nxt[register_Dest];
    end
  end

  assign current_PC = regs[PC_IDX];
  assign current_SP = regs[SP_IDX];

endmodule

// File: tb/tb_banked_reg_bank.sv
// Directed-vector bench for banked_reg_bank: reset, ops, forwarding, trap/return,
// illegal mode transitions, async reset and enable gating.
module tb_banked_reg_bank;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [2:0]  control;
  logic [3:0]  register_source_A;
  logic [3:0]  register_source_B;
  logic [3:0]  register_Dest;
  logic [31:0] ALU_result;
  logic [31:0] data_from_memory;
  logic [31:0] new_SP;
  logic [31:0] new_PC;
  logic [3:0]  special_register;
  logic [31:0] read_data_A;
  logic [31:0] read_data_B;
  logic [31:0] memory_output;
  logic [31:0] current_PC;
  logic [31:0] current_SP;
  logic        kernel_mode;
  logic        trap_fault;

  int checks = 0;
  int errors = 0;

  banked_reg_bank dut (
    .clock(clock), .reset(reset), .enable(enable), .control(control),
    .register_source_A(register_source_A), .register_source_B(register_source_B),
    .register_Dest(register_Dest), .ALU_result(ALU_result),
    .data_from_memory(data_from_memory), .new_SP(new_SP), .new_PC(new_PC),
    .special_register(special_register), .read_data_A(read_data_A),
    .read_data_B(read_data_B), .memory_output(memory_output),
    .current_PC(current_PC), .current_SP(current_SP),
    .kernel_mode(kernel_mode), .trap_fault(trap_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; control = 3'd0;
    register_source_A = 4'd0; register_source_B = 4'd0; register_Dest = 4'd0;
    ALU_result = '0; data_from_memory = '0; new_SP = '0; new_PC = '0;
    special_register = '0;
    step(); step();
    checks++; if (current_SP !== 32'd8191) begin errors++; $display("FAIL reset_sp: got %0d expected 8191", current_SP); end
    checks++; if (current_PC !== 32'd0) begin errors++; $display("FAIL reset_pc: got %0d expected 0", current_PC); end
    checks++; if (kernel_mode !== 1'b0) begin errors++; $display("FAIL reset_kmode: got %b expected 0", kernel_mode); end
    checks++; if (trap_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", trap_fault); end
    checks++; if (read_data_A !== 32'd0) begin errors++; $display("FAIL reset_rda: got %0h expected 0", read_data_A); end
    reset = 1'b0;
  endtask

  task automatic test_mem_load();
    enable = 1'b1; control = 3'd3; register_Dest = 4'd2;
    data_from_memory = 32'hDEAD; new_SP = 32'd8190; new_PC = 32'd1;
    step();
    checks++; if (memory_output !== 32'hDEAD) begin errors++; $display("FAIL mem_load_data: got %0h expected dead", memory_output); end
    checks++; if (current_SP !== 32'd8190) begin errors++; $display("FAIL mem_load_sp: got %0d expected 8190", current_SP); end
    checks++; if (current_PC !== 32'd1) begin errors++; $display("FAIL mem_load_pc: got %0d expected 1", current_PC); end
  endtask

  task automatic test_protected();
    control = 3'd1; register_Dest = 4'd15; ALU_result = 32'h55; new_PC = 32'd9;
    step();
    checks++; if (current_PC !== 32'd9) begin errors++; $display("FAIL prot_pc: got %0d expected 9", current_PC); end
    checks++; if (memory_output !== 32'd9) begin errors++; $display("FAIL prot_pc_read: got %0d expected 9", memory_output); end
    register_Dest = 4'd14; new_PC = 32'd10;
    step();
    checks++; if (current_SP !== 32'd8190) begin errors++; $display("FAIL prot_sp: got %0d expected 8190", current_SP); end
    checks++; if (current_PC !== 32'd10) begin errors++; $display("FAIL prot_sp_pc: got %0d expected 10", current_PC); end
  endtask

  task automatic test_forward();
    control = 3'd1; register_Dest = 4'd4; ALU_result = 32'h1111; new_PC = 32'd11;
    register_source_A = 4'd0; register_source_B = 4'd2;
    step();
    ALU_result = 32'h1234; register_source_A = 4'd4; new_PC = 32'd12;
    step();
    checks++; if (read_data_A !== 32'h1234) begin errors++; $display("FAIL forward_a: got %0h expected 1234", read_data_A); end
    checks++; if (read_data_B !== 32'hDEAD) begin errors++; $display("FAIL read_b: got %0h expected dead", read_data_B); end
    control = 3'd6; register_Dest = 4'd9; special_register = 4'hA; new_PC = 32'd13;
    step();
    checks++; if (memory_output !== 32'hA) begin errors++; $display("FAIL spec_write: got %0h expected a", memory_output); end
  endtask

  task automatic test_trap_return();
    control = 3'd0; new_SP = 32'd8000; new_PC = 32'd40;
    step();
    checks++; if (current_PC !== 32'd40 || current_SP !== 32'd8000) begin errors++; $display("FAIL set_pc_sp: got pc=%0d sp=%0d expected pc=40 sp=8000", current_PC, current_SP); end
    control = 3'd4; ALU_result = 32'd3; new_PC = 32'd99;
    register_source_A = 4'd13; register_source_B = 4'd5; register_Dest = 4'd7;
    step();
    checks++; if (current_PC !== 32'd2048) begin errors++; $display("FAIL trap_pc: got %0d expected 2048", current_PC); end
    checks++; if (current_SP !== 32'd6143) begin errors++; $display("FAIL trap_sp: got %0d expected 6143", current_SP); end
    checks++; if (read_data_A !== 32'd40) begin errors++; $display("FAIL trap_lr: got %0d expected 40", read_data_A); end
    checks++; if (read_data_B !== 32'd8000) begin errors++; $display("FAIL trap_saved_sp: got %0d expected 8000", read_data_B); end
    checks++; if (memory_output !== 32'd3) begin errors++; $display("FAIL trap_syscall: got %0d expected 3", memory_output); end
    checks++; if (kernel_mode !== 1'b1 || trap_fault !== 1'b0) begin errors++; $display("FAIL trap_mode: got k=%b f=%b expected k=1 f=0", kernel_mode, trap_fault); end
    control = 3'd0; new_SP = 32'd6100; new_PC = 32'd2050;
    step();
    checks++; if (current_SP !== 32'd6100) begin errors++; $display("FAIL kernel_sp_set: got %0d expected 6100", current_SP); end
    control = 3'd5; new_PC = 32'd77;
    step();
    checks++; if (current_PC !== 32'd40 || current_SP !== 32'd8000) begin errors++; $display("FAIL return_pc_sp: got pc=%0d sp=%0d expected pc=40 sp=8000", current_PC, current_SP); end
    checks++; if (kernel_mode !== 1'b0) begin errors++; $display("FAIL return_mode: got %b expected 0", kernel_mode); end
    control = 3'd4; ALU_result = 32'd9;
    step();
    checks++; if (current_SP !== 32'd6100) begin errors++; $display("FAIL retrap_sp: got %0d expected 6100", current_SP); end
    checks++; if (kernel_mode !== 1'b1) begin errors++; $display("FAIL retrap_mode: got %b expected 1", kernel_mode); end
  endtask

  task automatic test_illegal_modes();
    control = 3'd4; new_PC = 32'd2049; ALU_result = 32'd5;
    step();
    checks++; if (trap_fault !== 1'b1) begin errors++; $display("FAIL nested_fault: got %b expected 1", trap_fault); end
    checks++; if (current_PC !== 32'd2049) begin errors++; $display("FAIL nested_pc: got %0d expected 2049", current_PC); end
    checks++; if (current_SP !== 32'd6100) begin errors++; $display("FAIL nested_sp: got %0d expected 6100", current_SP); end
    checks++; if (read_data_A !== 32'd40 || read_data_B !== 32'd8000 || memory_output !== 32'd9) begin errors++; $display("FAIL nested_regs: got lr=%0d ssp=%0d sys=%0d expected 40 8000 9", read_data_A, read_data_B, memory_output); end
    control = 3'd0; new_SP = 32'd6100; new_PC = 32'd2050;
    step();
    checks++; if (trap_fault !== 1'b0) begin errors++; $display("FAIL nested_fault_width: got %b expected 0", trap_fault); end
    control = 3'd5;
    step();
    checks++; if (kernel_mode !== 1'b0 || current_PC !== 32'd40) begin errors++; $display("FAIL return2: got k=%b pc=%0d expected k=0 pc=40", kernel_mode, current_PC); end
    control = 3'd5; new_PC = 32'd60;
    step();
    checks++; if (trap_fault !== 1'b1) begin errors++; $display("FAIL user_ret_fault: got %b expected 1", trap_fault); end
    checks++; if (kernel_mode !== 1'b0 || current_PC !== 32'd60 || current_SP !== 32'd8000) begin errors++; $display("FAIL user_ret_state: got k=%b pc=%0d sp=%0d expected k=0 pc=60 sp=8000", kernel_mode, current_PC, current_SP); end
    control = 3'd0; new_SP = 32'd8000; new_PC = 32'd61;
    step();
    checks++; if (trap_fault !== 1'b0) begin errors++; $display("FAIL user_ret_fault_width: got %b expected 0", trap_fault); end
  endtask

  task automatic test_async_reset();
    control = 3'd4; ALU_result = 32'd1;
    step();
    checks++; if (kernel_mode !== 1'b1) begin errors++; $display("FAIL pre_reset_mode: got %b expected 1", kernel_mode); end
    #2 reset = 1'b1;
    #1;
    checks++; if (kernel_mode !== 1'b0) begin errors++; $display("FAIL async_reset_mode: got %b expected 0", kernel_mode); end
    checks++; if (current_SP !== 32'd8191 || current_PC !== 32'd0) begin errors++; $display("FAIL async_reset_sp_pc: got sp=%0d pc=%0d expected sp=8191 pc=0", current_SP, current_PC); end
    checks++; if (read_data_A !== 32'd0) begin errors++; $display("FAIL async_reset_rda: got %0h expected 0", read_data_A); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_enable_low();
    enable = 1'b1; control = 3'd1; register_Dest = 4'd3; ALU_result = 32'h77;
    register_source_A = 4'd3; new_PC = 32'd5;
    step();
    checks++; if (read_data_A !== 32'h77 || current_PC !== 32'd5) begin errors++; $display("FAIL pre_disable: got r3=%0h pc=%0d expected 77 5", read_data_A, current_PC); end
    enable = 1'b0; ALU_result = 32'h99; new_PC = 32'd123;
    step();
    checks++; if (read_data_A !== 32'h77) begin errors++; $display("FAIL disable_reg: got %0h expected 77", read_data_A); end
    checks++; if (current_PC !== 32'd5) begin errors++; $display("FAIL disable_pc: got %0d expected 5", current_PC); end
    control = 3'd4;
    step();
    checks++; if (kernel_mode !== 1'b0 || trap_fault !== 1'b0) begin errors++; $display("FAIL disable_trap: got k=%b f=%b expected 0 0", kernel_mode, trap_fault); end
  endtask

  initial begin
    test_reset();
    test_mem_load();
    test_protected();
    test_forward();
    test_trap_return();
    test_illegal_modes();
    test_async_reset();
    test_enable_low();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
